frame_buf_writer: RTL and testbench
===================================

FRAME_BUF_WRITER -- requirements
Module: frame_buf_writer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning input pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning input lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, meaning width of the per-bank address (covers (H_ACTIVE/2)*(V_ACTIVE/2)).
REQ-004 SHALL have ports:
- p_clock  in  1  pixel clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- vsync_en  in  1  one-cycle start-of-frame pulse.
- pixel_valid  in  1  one-cycle strobe; pixel_data valid.
- pixel_data  in  12  RGB444 {R,G,B}.
- frame_done  in  1  end-of-frame level/pulse from capture stage.
- wr_en  out  1  BRAM write enable.
- wr_addr  out  ADDR_W+1  {wr_bank, pixel address}.
- wr_data  out  12  BRAM write data.
- rd_bank  out  1  bank holding the last complete frame (for display side).
- frame_ok  out  1  one-cycle pulse: frame committed.
- frame_err  out  1  one-cycle pulse: frame dropped.
- frame_cnt  out  8  committed-frame count, wraps 255->0.

Function
REQ-005 SHALL implement FSM states WAIT_SOF, ACTIVE, COMMIT; reset state WAIT_SOF.
REQ-006 WAIT_SOF: SHALL ignore pixel_valid; on vsync_en go to ACTIVE and clear x, y, pixel total, and write address to 0.
REQ-007 ACTIVE: each pixel_valid cycle SHALL increment x; at x==H_ACTIVE-1, x wraps to 0 and y increments.
REQ-008 SHALL decimate 2:1 in each axis: write only pixels with x[0]==0 and y[0]==0; write address increments by 1 after each write (no multiplier).
REQ-009 Latency: wr_en, wr_addr, wr_data SHALL be registered, asserted exactly 1 cycle after the accepted pixel_valid; wr_en high for one cycle per written pixel.
REQ-010 Pixels arriving with y>=V_ACTIVE SHALL NOT be written; they SHALL set a sticky overflow flag for the frame.
REQ-011 ACTIVE: frame_done SHALL transition to COMMIT; a pixel_valid in the same cycle SHALL be counted/written first.
REQ-012 ACTIVE: vsync_en (no frame_done) SHALL restart the frame (counters cleared, stay ACTIVE) and pulse frame_err.
REQ-013 COMMIT (one cycle): if pixel total == H_ACTIVE*V_ACTIVE and no overflow, SHALL set rd_bank<=wr_bank, toggle wr_bank, increment frame_cnt, and pulse frame_ok; otherwise pulse frame_err with no bank change.
REQ-014 COMMIT SHALL go to ACTIVE (counters cleared) if vsync_en is high in that cycle, else to WAIT_SOF.
REQ-015 wr_bank and rd_bank SHALL never be equal after the first commit; writes SHALL never target rd_bank.
REQ-016 Pixel total counter SHALL saturate rather than wrap.

Reset
REQ-017 On rst: state WAIT_SOF, wr_en/frame_ok/frame_err 0, wr_addr 0, wr_data 0, wr_bank 0, rd_bank 1, frame_cnt 0, all counters and the overflow flag 0.
REQ-018 rst mid-frame SHALL abort immediately; the next frame SHALL start only on a fresh vsync_en.

Structure
REQ-019 State encodings and default H_ACTIVE/V_ACTIVE SHALL live in the shared camera package, also used by the capture stage.
REQ-020 SHALL be a single module; the BRAM is external, no sub-module.

Verification (bench uses H_ACTIVE=8, V_ACTIVE=4, ADDR_W=3)
REQ-021 vsync_en, then 32 pixel_valid with data=index, then frame_done -> 8 writes, addrs 0..7, data 0,2,4,6,16,18,20,22; frame_ok=1; rd_bank=0; frame_cnt=1.
REQ-022 Two complete frames back-to-back -> second frame writes use wr_addr MSB=1; after it, rd_bank=1 and frame_cnt=2.
REQ-023 vsync_en, 20 pixels, frame_done -> frame_err=1, rd_bank unchanged, frame_cnt unchanged.
REQ-024 vsync_en, 36 pixels, frame_done -> exactly 8 writes; frame_err=1 (overflow).
REQ-025 vsync_en, 10 pixels, vsync_en, 32 pixels, frame_done -> frame_err pulse at the second vsync_en; then frame_ok; first write of the restarted frame at addr 0.
REQ-026 rst asserted after 12 pixels -> all outputs at reset values next cycle; pixels before the next vsync_en produce no wr_en.

Source files
------------

// File: rtl/frame_buf_writer_pkg.sv
// Camera pipeline definitions shared by the capture stage and the frame buffer writer:
// default active video geometry and the writer FSM encoding.
package frame_buf_writer_pkg;

    localparam int CAM_H_ACTIVE = 640;
    localparam int CAM_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        COMMIT   = 2'd2
    } fbw_state_e;

endpackage

// File: rtl/frame_buf_writer.sv
// Writes a 2:1 x 2:1 decimated camera frame into one half of a ping-pong BRAM,
// then hands that bank to the display side only when the frame is complete.
module frame_buf_writer
    import frame_buf_writer_pkg::*;
#(
    parameter int H_ACTIVE = CAM_H_ACTIVE,
    parameter int V_ACTIVE = CAM_V_ACTIVE,
    parameter int ADDR_W   = 17
) (
    input  logic              p_clock,
    input  logic              rst,
    input  logic              vsync_en,
    input  logic              pixel_valid,
    input  logic [11:0]       pixel_data,
    input  logic              frame_done,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [11:0]       wr_data,
    output logic              rd_bank,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam int TW = $clog2(H_ACTIVE * V_ACTIVE + 1) + 1;

    localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_END     = YW'(V_ACTIVE);
    localparam logic [TW-1:0] TOTAL_CNT = TW'(H_ACTIVE * V_ACTIVE);
    localparam logic [TW-1:0] TOTAL_MAX = '1;

    fbw_state_e        state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [TW-1:0]     total_q, total_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic              frame_ok_q, frame_ok_d;
    logic              frame_err_q, frame_err_d;
    logic              clr;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        total_d     = total_q;
        addr_d      = addr_q;
        ovf_d       = ovf_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        frame_cnt_d = frame_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        clr         = 1'b0;

        case (state_q)
            WAIT_SOF: begin
                if (vsync_en) begin
                    state_d = ACTIVE;
                    clr     = 1'b1;
                end
            end
            ACTIVE: begin
                if (vsync_en && !frame_done) begin
                    clr         = 1'b1;
                    frame_err_d = 1'b1;
                end else begin
                    if (pixel_valid) begin
                        // Lines past the bottom edge are dropped and poison the frame.
                        if (y_q >= Y_END) begin
                            ovf_d = 1'b1;
                        end else if (!x_q[0] && !y_q[0]) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = {wr_bank_q, addr_q};
                            wr_data_d = pixel_data;
                            addr_d    = addr_q + 1'b1;
                        end
                        if (total_q != TOTAL_MAX) begin
                            total_d = total_q + 1'b1;
                        end
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            if (y_q < Y_END) begin
                                y_d = y_q + 1'b1;
                            end
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                    end
                    if (frame_done) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (total_q == TOTAL_CNT && !ovf_q) begin
                    rd_bank_d   = wr_bank_q;
                    wr_bank_d   = ~wr_bank_q;
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    frame_ok_d  = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
                if (vsync_en) begin
                    state_d = ACTIVE;
                    clr     = 1'b1;
                end else begin
                    state_d = WAIT_SOF;
                end
            end
            default: state_d = WAIT_SOF;
        endcase

        if (clr) begin
            x_d     = '0;
            y_d     = '0;
            total_d = '0;
            addr_d  = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge p_clock or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_SOF;
            x_q         <= '0;
            y_q         <= '0;
            total_q     <= '0;
            addr_q      <= '0;
            ovf_q       <= 1'b0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b1;
            frame_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            total_q     <= total_d;
            addr_q      <= addr_d;
            ovf_q       <= ovf_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            frame_cnt_q <= frame_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_bank   = rd_bank_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_buf_writer.sv
// Directed bench for frame_buf_writer on an 8x4 frame (4x2 decimated, 3-bit bank address).
module tb_frame_buf_writer;

    logic        p_clock;
    logic        rst;
    logic        vsync_en;
    logic        pixel_valid;
    logic [11:0] pixel_data;
    logic        frame_done;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data;
    logic        rd_bank;
    logic        frame_ok;
    logic        frame_err;
    logic [7:0]  frame_cnt;

    int total_n;
    int bad_n;
    int nw;
    logic [3:0]  wa [64];
    logic [11:0] wd [64];

    frame_buf_writer #(
        .H_ACTIVE (8),
        .V_ACTIVE (4),
        .ADDR_W   (3)
    ) dut (
        .p_clock     (p_clock),
        .rst         (rst),
        .vsync_en    (vsync_en),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .frame_done  (frame_done),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_bank     (rd_bank),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .frame_cnt   (frame_cnt)
    );

    initial p_clock = 1'b0;
    always #5 p_clock = ~p_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) else begin
            bad_n++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; any write produced by that edge is logged.
    task automatic step();
        @(posedge p_clock);
        #1;
        if (wr_en === 1'b1 && nw < 64) begin
            wa[nw] = wr_addr;
            wd[nw] = wr_data;
            nw++;
        end
    endtask

    task automatic sof();
        vsync_en = 1'b1;
        step();
        vsync_en = 1'b0;
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            pixel_valid = 1'b1;
            pixel_data  = 12'(i);
            step();
        end
        pixel_valid = 1'b0;
    endtask

    // frame_done edge enters COMMIT; the following edge registers the verdict.
    task automatic finish_frame();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
        step();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"},     32'(wr_en),     32'h0);
        chk({tag, "_wr_addr"},   32'(wr_addr),   32'h0);
        chk({tag, "_wr_data"},   32'(wr_data),   32'h0);
        chk({tag, "_rd_bank"},   32'(rd_bank),   32'h1);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'h0);
        chk({tag, "_frame_ok"},  32'(frame_ok),  32'h0);
        chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    endtask

    logic [11:0] exp_data [8];

    initial begin
        total_n     = 0;
        bad_n       = 0;
        nw          = 0;
        rst         = 1'b1;
        vsync_en    = 1'b0;
        pixel_valid = 1'b0;
        pixel_data  = '0;
        frame_done  = 1'b0;
        exp_data = '{12'd0, 12'd2, 12'd4, 12'd6, 12'd16, 12'd18, 12'd20, 12'd22};

        step();
        step();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Pixels before any vsync_en are ignored.
        nw = 0;
        pixels(3);
        chk("no_sof_writes", 32'(nw), 32'd0);

        // Complete frame into bank 0.
        sof();
        nw = 0;
        pixels(32);
        finish_frame();
        chk("fa_nwrites", 32'(nw), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fa_addr%0d", i), 32'(wa[i]), 32'(i));
            chk($sformatf("fa_data%0d", i), 32'(wd[i]), 32'(exp_data[i]));
        end
        chk("fa_ok",  32'(frame_ok),  32'h1);
        chk("fa_err", 32'(frame_err), 32'h0);
        chk("fa_rd_bank", 32'(rd_bank), 32'h0);
        chk("fa_cnt", 32'(frame_cnt), 32'd1);
        step();
        chk("fa_ok_pulse", 32'(frame_ok), 32'h0);

        // Second complete frame lands in bank 1.
        sof();
        nw = 0;
        pixels(32);
        finish_frame();
        chk("fb_nwrites", 32'(nw), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fb_addr%0d", i), 32'(wa[i]), 32'(8 + i));
        end
        chk("fb_ok", 32'(frame_ok), 32'h1);
        chk("fb_rd_bank", 32'(rd_bank), 32'h1);
        chk("fb_cnt", 32'(frame_cnt), 32'd2);

        // Short frame: dropped.
        sof();
        nw = 0;
        pixels(20);
        finish_frame();
        chk("short_nwrites", 32'(nw), 32'd6);
        chk("short_err", 32'(frame_err), 32'h1);
        chk("short_ok",  32'(frame_ok),  32'h0);
        chk("short_rd_bank", 32'(rd_bank), 32'h1);
        chk("short_cnt", 32'(frame_cnt), 32'd2);

        // Long frame: extra lines not written, frame dropped.
        sof();
        nw = 0;
        pixels(36);
        finish_frame();
        chk("long_nwrites", 32'(nw), 32'd8);
        chk("long_last_addr", 32'(wa[7]), 32'd7);
        chk("long_err", 32'(frame_err), 32'h1);
        chk("long_ok",  32'(frame_ok),  32'h0);
        chk("long_cnt", 32'(frame_cnt), 32'd2);
        chk("long_rd_bank", 32'(rd_bank), 32'h1);

        // Restart mid-frame with a second vsync_en.
        sof();
        pixels(10);
        vsync_en = 1'b1;
        step();
        vsync_en = 1'b0;
        chk("restart_err", 32'(frame_err), 32'h1);
        nw = 0;
        pixels(32);
        finish_frame();
        chk("restart_nwrites", 32'(nw), 32'd8);
        chk("restart_first_addr", 32'(wa[0]), 32'd0);
        chk("restart_first_data", 32'(wd[0]), 32'd0);
        chk("restart_ok",  32'(frame_ok),  32'h1);
        chk("restart_err_commit", 32'(frame_err), 32'h0);
        chk("restart_cnt", 32'(frame_cnt), 32'd3);
        chk("restart_rd_bank", 32'(rd_bank), 32'h0);

        // Reset mid-frame aborts; no writes until a fresh vsync_en.
        sof();
        pixels(12);
        rst = 1'b1;
        step();
        chk_reset_outputs("midrst");
        rst = 1'b0;
        nw = 0;
        pixels(5);
        chk("midrst_no_writes", 32'(nw), 32'd0);
        sof();
        nw = 0;
        pixels(3);
        chk("midrst_new_nwrites", 32'(nw), 32'd2);
        chk("midrst_new_addr", 32'(wa[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
